hoplite_packetiser: RTL and testbench
=====================================

# hoplite_packetiser

Outbound network-interface stage between the picorv32 `system` core and its Hoplite router injection port. It captures the destination coordinates and message words written by firmware through the memory-mapped NoC outputs. On the packet-complete strobe it injects the buffered words into the router as a burst of flits, one flit per accepted cycle. Each flit carries source and destination coordinates and a last-flit marker.

## Interface
- `COORD_BITS`, 1, width of each X/Y coordinate
- `DATA_WIDTH`, 32, message word width
- `FIFO_DEPTH`, 8, maximum message words per packet; power of two, ≥2
- `X_COORD`, 0, this node's X coordinate (source field)
- `Y_COORD`, 0, this node's Y coordinate (source field)
- `FLIT_WIDTH`, 1+4*COORD_BITS+DATA_WIDTH, derived; not overridden
- `clk`  in  1  single clock, all logic rising-edge
- `reset`  in  1  synchronous, active-high reset
- `x_coord_in`  in  COORD_BITS  destination X from core
- `x_coord_in_valid`  in  1  one-cycle strobe, latch `x_coord_in`
- `y_coord_in`  in  COORD_BITS  destination Y from core
- `y_coord_in_valid`  in  1  one-cycle strobe, latch `y_coord_in`
- `message_in`  in  DATA_WIDTH  message word from core
- `message_in_valid`  in  1  one-cycle strobe, enqueue `message_in`
- `packet_complete_in`  in  1  one-cycle strobe, start injection
- `pe_out`  out  FLIT_WIDTH  flit {last, src_y, src_x, dest_y, dest_x, data}, MSB first
- `pe_out_valid`  out  1  flit on `pe_out` is valid
- `pe_out_ready`  in  1  router accepts the injected flit this cycle
- `busy`  out  1  high while in SEND; firmware polls it before writing
- `message_count`  out  $clog2(FIFO_DEPTH)+1  words currently buffered
- `overflow`  out  1  sticky; a write was dropped

## Operation
- FSM states: COLLECT (reset state) and SEND.
- COLLECT:
  - `x_coord_in_valid` and `y_coord_in_valid` each load their destination register independently. The last write wins.
  - `message_in_valid` writes to the FIFO tail when count < FIFO_DEPTH. When the FIFO is full, the word is dropped and `overflow` is set.
  - `packet_complete_in` with count > 0 moves the FSM to SEND.
  - `packet_complete_in` with count == 0 is ignored and no flit is emitted.
- Simultaneous `message_in_valid` and `packet_complete_in` in COLLECT: the word is enqueued first and is included in the packet. If the FIFO is full, the word is dropped, `overflow` is set, and the packet is still sent.
- SEND:
  - `pe_out_valid` is 1 and `pe_out` shows the FIFO head plus the destination registers.
  - `src_x` = X_COORD and `src_y` = Y_COORD.
  - `last` = 1 exactly when count == 1.
  - On `pe_out_valid && pe_out_ready`, the head is popped.
  - After the last flit is popped, the FSM returns to COLLECT.
- SEND input handling: coordinate strobes and `packet_complete_in` are ignored. `message_in_valid` is dropped and sets `overflow`.
- FIFO: circular buffer with read/write pointers of width $clog2(FIFO_DEPTH). Pointers wrap modulo FIFO_DEPTH. A separate count register provides full/empty.
- `overflow` is cleared only by `reset`.
- Reset values:
  - state = COLLECT
  - pointers, count and `message_count` = 0
  - destination registers = 0
  - `pe_out_valid` = 0, `busy` = 0, `overflow` = 0
  - `pe_out` = 0 whenever `pe_out_valid` = 0
- Reset asserted mid-SEND aborts the packet. The remaining words are discarded and `pe_out_valid` is 0 in the cycle after reset is sampled.

## Timing
- `packet_complete_in` sampled at edge N: `busy` and `pe_out_valid` are high from N+1.
- Throughput is one flit per cycle while `pe_out_ready` = 1. An n-word packet with ready held high occupies cycles N+1 through N+n.
- After the last transfer at edge M, `busy` = 0 and `message_count` = 0 from M+1. A new message write is accepted at M+1.
- Once `pe_out_valid` rises, it and `pe_out` stay stable until accepted. Backpressure (`pe_out_ready` = 0) holds the current flit indefinitely.
- `pe_out_valid` does not depend combinationally on `pe_out_ready`.
- `message_count` reflects writes one cycle after the strobe edge.

## Test plan
- Reset, then set dest (1,0), write 0xA, 0xB, 0xC, pulse complete, hold ready = 1 -> three consecutive flits with data A, B, C, dest_x = 1, dest_y = 0, last = 0, 0, 1. `busy` falls on the cycle after the C transfer.
- Same packet with `pe_out_ready` toggled 1,0,0,1,1 -> each flit held stable while ready = 0, order preserved, no duplicates.
- Write FIFO_DEPTH+1 (9) words, then complete -> `overflow` = 1, exactly 8 flits emitted, the ninth word absent.
- `packet_complete_in` with an empty FIFO -> `pe_out_valid` stays 0, `busy` stays 0.
- `message_in_valid` in the same cycle as `packet_complete_in` after 2 words -> 3 flits emitted, the third last. A write during SEND -> dropped and `overflow` set.
- Reset asserted after the first flit of a 4-word packet -> `pe_out_valid` = 0 next cycle, `message_count` = 0, state COLLECT. A subsequent 1-word packet is sent with last = 1.

Source files
------------

// File: rtl/hoplite_packetiser_if.sv
// Core-side write strobes and router-side injection handshake of the Hoplite packetiser.
// The slave modport is the packetiser's view; the master modport drives it.
interface hoplite_packetiser_if #(
  parameter int COORD_BITS = 1,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8
);
  localparam int FLIT_WIDTH = 1 + 4*COORD_BITS + DATA_WIDTH;
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

  logic [COORD_BITS-1:0] x_coord_in;
  logic                  x_coord_in_valid;
  logic [COORD_BITS-1:0] y_coord_in;
  logic                  y_coord_in_valid;
  logic [DATA_WIDTH-1:0] message_in;
  logic                  message_in_valid;
  logic                  packet_complete_in;
  logic [FLIT_WIDTH-1:0] pe_out;
  logic                  pe_out_valid;
  logic                  pe_out_ready;
  logic                  busy;
  logic [CNT_W-1:0]      message_count;
  logic                  overflow;

  modport slave (
    input  x_coord_in, x_coord_in_valid, y_coord_in, y_coord_in_valid,
    input  message_in, message_in_valid, packet_complete_in, pe_out_ready,
    output pe_out, pe_out_valid, busy, message_count, overflow
  );

  modport master (
    output x_coord_in, x_coord_in_valid, y_coord_in, y_coord_in_valid,
    output message_in, message_in_valid, packet_complete_in, pe_out_ready,
    input  pe_out, pe_out_valid, busy, message_count, overflow
  );
endinterface

// File: rtl/hoplite_packetiser.sv
// Buffers firmware-written message words and injects them into a Hoplite router
// as a burst of flits {last, src_y, src_x, dest_y, dest_x, data}.
module hoplite_packetiser #(
  parameter int COORD_BITS = 1,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int X_COORD    = 0,
  parameter int Y_COORD    = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  hoplite_packetiser_if.slave  bus
);
  localparam int FLIT_WIDTH = 1 + 4*COORD_BITS + DATA_WIDTH;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = PTR_W + 1;

  localparam logic [0:0] S_COLLECT = 1'b0;
  localparam logic [0:0] S_SEND    = 1'b1;

  localparam logic [CNT_W-1:0]      DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]      ONE_C   = CNT_W'(1);
  localparam logic [PTR_W-1:0]      PTR_ONE = PTR_W'(1);
  localparam logic [COORD_BITS-1:0] SRC_X   = COORD_BITS'(X_COORD);
  localparam logic [COORD_BITS-1:0] SRC_Y   = COORD_BITS'(Y_COORD);

  logic [0:0]            state_q,    state_d;
  logic [PTR_W-1:0]      rd_ptr_q,   rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q,   wr_ptr_d;
  logic [CNT_W-1:0]      count_q,    count_d;
  logic [COORD_BITS-1:0] dest_x_q,   dest_x_d;
  logic [COORD_BITS-1:0] dest_y_q,   dest_y_d;
  logic                  overflow_q, overflow_d;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [FLIT_WIDTH-1:0] flit;

  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    dest_x_d   = dest_x_q;
    dest_y_d   = dest_y_q;
    overflow_d = overflow_q;
    wr_en      = 1'b0;
    if (state_q == S_COLLECT) begin
      if (bus.x_coord_in_valid) dest_x_d = bus.x_coord_in;
      if (bus.y_coord_in_valid) dest_y_d = bus.y_coord_in;
      if (bus.message_in_valid) begin
        if (count_q != DEPTH_C) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_ONE;
          count_d  = count_q + ONE_C;
        end else begin
          overflow_d = 1'b1;
        end
      end
      // A word written alongside the complete strobe joins this packet.
      if (bus.packet_complete_in && ((count_q != '0) || wr_en)) state_d = S_SEND;
    end else begin
      if (bus.message_in_valid) overflow_d = 1'b1;
      if (bus.pe_out_ready) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        count_d  = count_q - ONE_C;
        if (count_q == ONE_C) state_d = S_COLLECT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_COLLECT;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      dest_x_q   <= '0;
      dest_y_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      dest_x_q   <= dest_x_d;
      dest_y_q   <= dest_y_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= bus.message_in;
  end

  assign flit = {(count_q == ONE_C), SRC_Y, SRC_X, dest_y_q, dest_x_q, mem_q[rd_ptr_q]};

  assign bus.pe_out        = (state_q == S_SEND) ? flit : '0;
  assign bus.pe_out_valid  = (state_q == S_SEND);
  assign bus.busy          = (state_q == S_SEND);
  assign bus.message_count = count_q;
  assign bus.overflow      = overflow_q;
endmodule

// File: tb/tb_hoplite_packetiser.sv
// Scoreboard bench for hoplite_packetiser: a packet-level reference model queues the
// expected flits, and a negedge monitor compares every presented flit against them.
module tb_hoplite_packetiser;
  localparam int CB = 1;
  localparam int DW = 32;
  localparam int FD = 8;
  localparam int XC = 1;
  localparam int YC = 0;
  localparam int FW = 1 + 4*CB + DW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hoplite_packetiser_if #(.COORD_BITS(CB), .DATA_WIDTH(DW), .FIFO_DEPTH(FD)) bus ();

  hoplite_packetiser #(
    .COORD_BITS(CB), .DATA_WIDTH(DW), .FIFO_DEPTH(FD), .X_COORD(XC), .Y_COORD(YC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: words waiting in the buffer, flits still owed to the router.
  logic [DW-1:0] buf_m[$];
  logic [FW-1:0] exp_q[$];
  int            in_flight = 0;
  logic          ovf_m = 1'b0;
  logic [CB-1:0] dx_m = '0, dy_m = '0;
  logic [CB-1:0] src_x = XC, src_y = YC;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every valid cycle must show the scoreboard head; pop on acceptance.
  always @(negedge clk) begin
    if (bus.pe_out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_flit", 64'(bus.pe_out), 64'hDEAD_0000_0000_0000);
      end else begin
        chk("flit", 64'(bus.pe_out), 64'(exp_q[0]));
        if (bus.pe_out_ready === 1'b1) void'(exp_q.pop_front());
      end
    end
  end

  // One clock of stimulus; the model advances on the same edge, outputs checked #1 later.
  task automatic step(input logic rst_i, input logic xv, input logic [CB-1:0] x,
                      input logic yv, input logic [CB-1:0] y,
                      input logic mv, input logic [DW-1:0] m,
                      input logic pc, input logic rdy);
    int n;
    reset                  = rst_i;
    bus.x_coord_in_valid   = xv;
    bus.x_coord_in         = x;
    bus.y_coord_in_valid   = yv;
    bus.y_coord_in         = y;
    bus.message_in_valid   = mv;
    bus.message_in         = m;
    bus.packet_complete_in = pc;
    bus.pe_out_ready       = rdy;
    @(posedge clk);
    if (rst_i) begin
      buf_m.delete();
      exp_q.delete();
      in_flight = 0;
      ovf_m     = 1'b0;
      dx_m      = '0;
      dy_m      = '0;
    end else if (in_flight > 0) begin
      if (mv) ovf_m = 1'b1;
      if (rdy) in_flight--;
    end else begin
      if (xv) dx_m = x;
      if (yv) dy_m = y;
      if (mv) begin
        if (buf_m.size() < FD) buf_m.push_back(m);
        else ovf_m = 1'b1;
      end
      if (pc && buf_m.size() > 0) begin
        n = buf_m.size();
        for (int i = 0; i < n; i++)
          exp_q.push_back({(i == n-1), src_y, src_x, dy_m, dx_m, buf_m[i]});
        in_flight = n;
        buf_m.delete();
      end
    end
    #1;
    chk("busy", 64'(bus.busy), 64'(in_flight > 0));
    chk("pe_out_valid", 64'(bus.pe_out_valid), 64'(in_flight > 0));
    chk("message_count", 64'(bus.message_count),
        64'((in_flight > 0) ? in_flight : buf_m.size()));
    chk("overflow", 64'(bus.overflow), 64'(ovf_m));
    if (in_flight == 0) chk("pe_out_idle", 64'(bus.pe_out), 64'd0);
  endtask

  task automatic do_reset();
    step(1, 0, '0, 0, '0, 0, '0, 0, 0);
    step(1, 0, '0, 0, '0, 0, '0, 0, 0);
  endtask
  task automatic idle(input logic rdy);
    step(0, 0, '0, 0, '0, 0, '0, 0, rdy);
  endtask
  task automatic wr(input logic [DW-1:0] m);
    step(0, 0, '0, 0, '0, 1, m, 0, 1);
  endtask
  task automatic complete();
    step(0, 0, '0, 0, '0, 0, '0, 1, 1);
  endtask
  task automatic set_dest(input logic [CB-1:0] x, input logic [CB-1:0] y);
    step(0, 1, x, 1, y, 0, '0, 0, 1);
  endtask
  task automatic drain();
    for (int i = 0; i < 40 && in_flight > 0; i++) idle(1);
    idle(1);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.x_coord_in_valid = 0; bus.x_coord_in = '0;
    bus.y_coord_in_valid = 0; bus.y_coord_in = '0;
    bus.message_in_valid = 0; bus.message_in = '0;
    bus.packet_complete_in = 0; bus.pe_out_ready = 0;
    @(posedge clk); #1;
    do_reset();

    // Three-word packet to (1,0) with ready held high.
    set_dest(1, 0);
    wr(32'hA); wr(32'hB); wr(32'hC);
    complete();
    drain();

    // Same packet under backpressure.
    wr(32'hA); wr(32'hB); wr(32'hC);
    complete();
    idle(1); idle(0); idle(0); idle(1); idle(1);
    drain();

    // Nine writes into an eight-deep buffer.
    for (int i = 0; i < FD + 1; i++) wr(32'h100 + 32'(i));
    complete();
    drain();

    // Complete with nothing buffered.
    complete();
    idle(1); idle(1);

    // Write coinciding with complete, then a write during SEND.
    do_reset();
    set_dest(0, 1);
    wr(32'h11); wr(32'h22);
    step(0, 0, '0, 0, '0, 1, 32'h33, 1, 0);
    idle(0);
    wr(32'h44);
    drain();

    // Reset after the first flit of a four-word packet, then a one-word packet.
    set_dest(1, 1);
    for (int i = 0; i < 4; i++) wr(32'h200 + 32'(i));
    complete();
    idle(1);
    step(1, 0, '0, 0, '0, 0, '0, 0, 0);
    idle(1);
    wr(32'h5A5A);
    complete();
    drain();

    // Randomised traffic.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      step(0, ($urandom % 4) == 0, CB'($urandom), ($urandom % 4) == 0, CB'($urandom),
           ($urandom % 3) == 0, $urandom, ($urandom % 7) == 0, ($urandom % 4) != 0);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
